// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous input in clock_in cycles.
// Optional frequency/duty self-check is built when DUTY_CHECK_EN is defined.
module clock_period_meter #(
    parameter int unsigned      WIDTH       = 28,
    parameter logic [WIDTH-1:0] TIMEOUT     = 28'd1000000,
    parameter int unsigned      SYNC_STAGES = 2
`ifdef DUTY_CHECK_EN
    ,
    parameter logic [WIDTH-1:0] EXP_PERIOD  = 28'd2,
    parameter logic [WIDTH-1:0] TOL         = 28'd0
`endif
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             meas_valid,
    output logic             stalled
`ifdef DUTY_CHECK_EN
    ,
    output logic             freq_err,
    output logic             duty_err
`endif
);

    typedef enum logic {
        ARM     = 1'b0,
        MEASURE = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       hi_lat_q, hi_lat_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [WIDTH-1:0]       high_q, high_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   stalled_q, stalled_d;

    logic synced;
    logic rise_det;
    logic fall_det;
    logic timeout_hit;

    assign synced      = sync_q[SYNC_STAGES-1];
    assign rise_det    = synced & ~prev_q;
    assign fall_det    = ~synced & prev_q;
    assign timeout_hit = (cnt_q == TIMEOUT);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d = synced;
        if (rise_det) begin
            cnt_d = WIDTH'(1);
        end else if (timeout_hit) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (rise_det) state_d = MEASURE;
            MEASURE: if (!rise_det && timeout_hit) state_d = ARM;
            default: state_d = ARM;
        endcase
    end

    // FSM: outputs and latched measurements
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        period_d     = period_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        stalled_d    = stalled_q;
        hi_lat_d     = hi_lat_q;

        if (rise_det) begin
            hi_lat_d = '0;
        end else if (state_q == MEASURE && fall_det) begin
            hi_lat_d = cnt_q;
        end

        if (state_q == MEASURE) begin
            if (rise_det) begin
                period_d     = cnt_q;
                high_d       = hi_lat_q;
                meas_valid_d = 1'b1;
                stalled_d    = 1'b0;
            end else if (timeout_hit) begin
                stalled_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        // NOTE: the synchronizer chain is reset too, so a level held across reset shows up as a fresh edge.
        if (reset) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            hi_lat_q     <= '0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            stalled_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            hi_lat_q     <= hi_lat_d;
            period_q     <= period_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            stalled_q    <= stalled_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign meas_valid = meas_valid_q;
    assign stalled    = stalled_q;

`ifdef DUTY_CHECK_EN
    logic             freq_err_q, freq_err_d;
    logic             duty_err_q, duty_err_d;
    logic [WIDTH-1:0] period_dev;
    logic [WIDTH:0]   twice_high;
    logic [WIDTH:0]   period_ext;
    logic [WIDTH:0]   duty_dev;

    // Flags are judged on the values being latched into period_out/high_out.
    always_comb begin
        period_dev = (cnt_q >= EXP_PERIOD) ? (cnt_q - EXP_PERIOD) : (EXP_PERIOD - cnt_q);
        twice_high = {hi_lat_q, 1'b0};
        period_ext = {1'b0, cnt_q};
        duty_dev   = (twice_high >= period_ext) ? (twice_high - period_ext)
                                                : (period_ext - twice_high);
        freq_err_d = freq_err_q;
        duty_err_d = duty_err_q;
        if (meas_valid_d) begin
            freq_err_d = (period_dev > TOL);
            duty_err_d = (duty_dev > (WIDTH+1)'(1));
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            freq_err_q <= 1'b0;
            duty_err_q <= 1'b0;
        end else begin
            freq_err_q <= freq_err_d;
            duty_err_q <= duty_err_d;
        end
    end

    assign freq_err = freq_err_q;
    assign duty_err = duty_err_q;
`endif

endmodule
